// File: rtl/tmds_word_aligner.sv
// TMDS lane word-boundary aligner: hunts for control-token runs by pulsing the
// de-serializer BITSLIP, declares lock, and restarts the hunt when tokens stop.
module tmds_word_aligner #(
  parameter int unsigned TOKEN_RUN      = 8,
  parameter int unsigned SEARCH_TIMEOUT = 4096,
  parameter int unsigned SETTLE_CYCLES  = 8,
  parameter int unsigned LOCK_TIMEOUT   = 65536,
  parameter int unsigned MAX_SLIPS      = 10
) (
  input  logic       i_pixclk,
  input  logic       i_rstn,
  input  logic [9:0] i_encoded_data,
  input  logic       i_realign,
  output logic       o_bitslip,
  output logic       o_aligned,
  output logic [3:0] o_slip_count,
  output logic       o_align_fail
);

  // Run counter must hold TOKEN_RUN itself because it saturates there.
  localparam int unsigned RW = $clog2(TOKEN_RUN + 1);
  localparam int unsigned TW = (SEARCH_TIMEOUT > 1) ? $clog2(SEARCH_TIMEOUT) : 1;
  localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned LW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

  localparam logic [RW-1:0] RUN_SAT     = RW'(TOKEN_RUN);
  localparam logic [RW-1:0] RUN_LAST    = RW'(TOKEN_RUN - 1);
  localparam logic [TW-1:0] SEARCH_LAST = TW'(SEARCH_TIMEOUT - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [LW-1:0] LOCK_LAST   = LW'(LOCK_TIMEOUT - 1);
  localparam logic [3:0]    SLIP_LAST   = 4'(MAX_SLIPS - 1);

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_SLIP,
    ST_SETTLE,
    ST_LOCKED
  } state_t;

  state_t        state;
  logic [9:0]    prev_word;
  logic [RW-1:0] run_cnt;
  logic [TW-1:0] search_cnt;
  logic [SW-1:0] settle_cnt;
  logic [LW-1:0] lock_cnt;
  logic          realign_pend;

  logic is_tok, same_word, run_hit, realign_now, detect_on;

  always_comb begin
    is_tok      = (i_encoded_data == 10'h354) || (i_encoded_data == 10'h0AB) ||
                  (i_encoded_data == 10'h154) || (i_encoded_data == 10'h2AB);
    same_word   = (i_encoded_data == prev_word);
    detect_on   = (state == ST_SEARCH) || (state == ST_LOCKED);
    run_hit     = detect_on && is_tok && same_word && (run_cnt == RUN_LAST);
    // A realign seen during SLIP is remembered and acted on one cycle later.
    realign_now = (i_realign || realign_pend) && (state != ST_SLIP);
  end

  always_ff @(posedge i_pixclk or negedge i_rstn) begin
    if (!i_rstn) begin
      state        <= ST_SEARCH;
      prev_word    <= '0;
      run_cnt      <= '0;
      search_cnt   <= '0;
      settle_cnt   <= '0;
      lock_cnt     <= '0;
      realign_pend <= 1'b0;
      o_bitslip    <= 1'b0;
      o_aligned    <= 1'b0;
      o_slip_count <= '0;
      o_align_fail <= 1'b0;
    end else begin
      o_bitslip    <= 1'b0;
      o_align_fail <= 1'b0;
      realign_pend <= (state == ST_SLIP) && i_realign;

      if (!detect_on) begin
        prev_word <= '0;
        run_cnt   <= '0;
      end else begin
        prev_word <= i_encoded_data;
        if (!is_tok)
          run_cnt <= '0;
        else if (!same_word)
          run_cnt <= RW'(1);
        else if (run_cnt != RUN_SAT)
          run_cnt <= run_cnt + RW'(1);
      end

      if (realign_now) begin
        state        <= ST_SEARCH;
        prev_word    <= '0;
        run_cnt      <= '0;
        search_cnt   <= '0;
        settle_cnt   <= '0;
        lock_cnt     <= '0;
        o_aligned    <= 1'b0;
        o_slip_count <= '0;
      end else begin
        case (state)
          ST_SEARCH: begin
            if (run_hit) begin
              state      <= ST_LOCKED;
              o_aligned  <= 1'b1;
              search_cnt <= '0;
              lock_cnt   <= '0;
            end else if (search_cnt == SEARCH_LAST) begin
              state      <= ST_SLIP;
              search_cnt <= '0;
              o_bitslip  <= 1'b1;
              if (o_slip_count == SLIP_LAST) begin
                o_slip_count <= '0;
                o_align_fail <= 1'b1;
              end else begin
                o_slip_count <= o_slip_count + 4'd1;
              end
            end else begin
              search_cnt <= search_cnt + TW'(1);
            end
          end
          ST_SLIP: begin
            state      <= ST_SETTLE;
            settle_cnt <= '0;
          end
          ST_SETTLE: begin
            if (settle_cnt == SETTLE_LAST) begin
              state      <= ST_SEARCH;
              search_cnt <= '0;
              settle_cnt <= '0;
            end else begin
              settle_cnt <= settle_cnt + SW'(1);
            end
          end
          ST_LOCKED: begin
            if (run_hit) begin
              lock_cnt <= '0;
            end else if (lock_cnt == LOCK_LAST) begin
              state      <= ST_SEARCH;
              o_aligned  <= 1'b0;
              search_cnt <= '0;
              lock_cnt   <= '0;
            end else begin
              lock_cnt <= lock_cnt + LW'(1);
            end
          end
          default: state <= ST_SEARCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tmds_word_aligner.sv
// Directed bench for tmds_word_aligner with short timeouts; optional barrel-shift
// model of the de-serializer reacts to o_bitslip.
module tb_tmds_word_aligner;

  localparam logic [9:0] TOK  = 10'h354;
  localparam logic [9:0] ROT3 = 10'h2A6;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] din;
  logic       realign;
  logic       bitslip, aligned, align_fail;
  logic [3:0] slip_count;

  int          checks = 0;
  int          failures = 0;
  int unsigned slips_seen = 0;
  int unsigned fails_seen = 0;
  bit          use_model = 1'b0;
  int unsigned ofs = 0;

  always #5 clk = ~clk;

  tmds_word_aligner #(
    .TOKEN_RUN     (8),
    .SEARCH_TIMEOUT(16),
    .SETTLE_CYCLES (4),
    .LOCK_TIMEOUT  (64),
    .MAX_SLIPS     (10)
  ) dut (
    .i_pixclk      (clk),
    .i_rstn        (rst_n),
    .i_encoded_data(din),
    .i_realign     (realign),
    .o_bitslip     (bitslip),
    .o_aligned     (aligned),
    .o_slip_count  (slip_count),
    .o_align_fail  (align_fail)
  );

  function automatic logic [9:0] rotl(input logic [9:0] w, input int unsigned r);
    return (w << r) | (w >> (10 - r));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bitslip) slips_seen++;
    if (align_fail) fails_seen++;
    if (use_model) begin
      if (bitslip) ofs = (ofs + 1) % 10;
      din = rotl(TOK, ofs);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    realign = 1'b0;
    #2;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n   = 1'b0;
    realign = 1'b0;
    din     = TOK;
    #12;
    chk("rst_bitslip", 32'(bitslip), 32'd0);
    chk("rst_aligned", 32'(aligned), 32'd0);
    chk("rst_slip_count", 32'(slip_count), 32'd0);
    chk("rst_align_fail", 32'(align_fail), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Aligned token stream: lock on the 8th identical token.
    slips_seen = 0;
    ticks(7);
    chk("run7_not_locked", 32'(aligned), 32'd0);
    tick();
    chk("run8_locked", 32'(aligned), 32'd1);
    chk("no_slip_when_aligned", slips_seen, 32'd0);

    // Token-free data after lock: lock lost after exactly 64 cycles.
    din = 10'h000;
    ticks(63);
    chk("lock_held_63", 32'(aligned), 32'd1);
    tick();
    chk("lock_lost_64", 32'(aligned), 32'd0);
    chk("lock_lost_slip_count", 32'(slip_count), 32'd0);

    // Never-matching stream: 10 slips, spaced 21 cycles, wrap with align_fail.
    din = ROT3;
    do_reset();
    slips_seen = 0;
    fails_seen = 0;
    ticks(15);
    chk("first_slip_not_early", slips_seen, 32'd0);
    tick();
    chk("slip1_pulse", 32'(bitslip), 32'd1);
    chk("slip1_count", 32'(slip_count), 32'd1);
    chk("slip1_no_fail", 32'(align_fail), 32'd0);
    for (int k = 2; k <= 10; k++) begin
      ticks(20);
      chk("slip_spacing_quiet", slips_seen, 32'(k - 1));
      tick();
      chk("slip_pulse", 32'(bitslip), 32'd1);
      chk("slip_count_seq", 32'(slip_count), 32'(k % 10));
      chk("align_fail_at_wrap", 32'(align_fail), 32'(k == 10));
    end
    tick();
    chk("bitslip_one_cycle", 32'(bitslip), 32'd0);
    chk("align_fail_one_cycle", 32'(align_fail), 32'd0);
    chk("align_fail_count", fails_seen, 32'd1);

    // Stream aligns after two modelled slips (offset 8 -> 9 -> 0).
    use_model = 1'b1;
    ofs = 8;
    din = rotl(TOK, 8);
    do_reset();
    slips_seen = 0;
    ticks(49);
    chk("model_two_slips", slips_seen, 32'd2);
    chk("model_not_yet_locked", 32'(aligned), 32'd0);
    tick();
    chk("model_locked", 32'(aligned), 32'd1);
    chk("model_slip_count", 32'(slip_count), 32'd2);

    // Realign while locked.
    realign = 1'b1;
    tick();
    realign = 1'b0;
    chk("realign_aligned", 32'(aligned), 32'd0);
    chk("realign_slip_count", 32'(slip_count), 32'd0);
    use_model = 1'b0;

    // Seven-token run then a different token: no lock.
    din = TOK;
    do_reset();
    ticks(7);
    din = 10'h0AB;
    tick();
    din = 10'h000;
    ticks(6);
    chk("run7_break_no_lock", 32'(aligned), 32'd0);

    // Realign during SLIP: deferred one cycle, pulse intact.
    din = ROT3;
    do_reset();
    slips_seen = 0;
    ticks(16);
    chk("slip_before_realign", 32'(bitslip), 32'd1);
    realign = 1'b1;
    tick();
    realign = 1'b0;
    chk("realign_in_slip_pulse_end", 32'(bitslip), 32'd0);
    chk("realign_in_slip_deferred", 32'(slip_count), 32'd1);
    tick();
    chk("realign_in_slip_applied", 32'(slip_count), 32'd0);
    chk("realign_single_pulse", slips_seen, 32'd1);
    ticks(15);
    chk("realign_full_timeout", slips_seen, 32'd1);
    tick();
    chk("realign_next_slip", 32'(bitslip), 32'd1);
    chk("realign_next_count", 32'(slip_count), 32'd1);

    // Async reset mid-SLIP and mid-SETTLE.
    do_reset();
    ticks(16);
    chk("pre_reset_slip", 32'(bitslip), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_mid_slip_bitslip", 32'(bitslip), 32'd0);
    chk("reset_mid_slip_count", 32'(slip_count), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    slips_seen = 0;
    ticks(15);
    chk("post_reset1_quiet", slips_seen, 32'd0);
    tick();
    chk("post_reset1_slip", 32'(bitslip), 32'd1);
    ticks(2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_settle_bitslip", 32'(bitslip), 32'd0);
    chk("reset_settle_aligned", 32'(aligned), 32'd0);
    chk("reset_settle_count", 32'(slip_count), 32'd0);
    chk("reset_settle_fail", 32'(align_fail), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    slips_seen = 0;
    ticks(15);
    chk("post_reset2_quiet", slips_seen, 32'd0);
    tick();
    chk("post_reset2_slip", 32'(bitslip), 32'd1);
    chk("post_reset2_count", 32'(slip_count), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
